point_in_tri_pipe: RTL and testbench

POINT_IN_TRI_PIPE -- requirements
Module: point_in_tri_pipe

---
 rtl/point_in_tri_pipe.sv | 257 +++++++++++++++++++++++++
 tb/tb_point_in_tri_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_in_tri_pipe.sv
`default_nettype none
// ============================================================================
// Module      : point_in_tri_pipe
// Description : Point-in-triangle tester. A triangle is loaded and its
//               orientation is latched. Test points then flow through a
//               3-stage pipeline (differences, products, edge compare) into a
//               result FIFO with ready/valid flow control.
//               Macro POINT_IN_TRI_EDGE_INCLUSIVE_EN makes points lying on
//               an edge or a vertex count as inside.
// Revision    : 1.0 - initial release
// ============================================================================
module point_in_tri_pipe #(
    parameter int COORD_W = 11,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] tri_p1x,
    input  logic [COORD_W-1:0] tri_p1y,
    input  logic [COORD_W-1:0] tri_p2x,
    input  logic [COORD_W-1:0] tri_p2y,
    input  logic [COORD_W-1:0] tri_p3x,
    input  logic [COORD_W-1:0] tri_p3y,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_inside,
    output logic               res_degenerate,
    output logic [15:0]        res_index,
    output logic               busy
);

    localparam int c_DW = COORD_W + 1;       // signed difference width
    localparam int c_PW = 2 * COORD_W + 2;   // signed product / edge width
    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW+1:0] c_DEPTH = (c_AW+2)'(DEPTH);

`ifdef POINT_IN_TRI_EDGE_INCLUSIVE_EN
    localparam logic c_EDGE_INCL = 1'b1;
`else
    localparam logic c_EDGE_INCL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_NO_TRI = 2'd0,
        S_SETUP  = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    // Unsigned coordinates widened by one bit so the difference is exact
    function automatic logic signed [c_DW-1:0] diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    // Full-width signed product; magnitudes stay below 2^(2*COORD_W)
    function automatic logic signed [c_PW-1:0] mul(input logic signed [c_DW-1:0] a,
                                                   input logic signed [c_DW-1:0] b);
        logic signed [c_PW-1:0] ea;
        logic signed [c_PW-1:0] eb;
        ea = {{(c_PW-c_DW){a[c_DW-1]}}, a};
        eb = {{(c_PW-c_DW){b[c_DW-1]}}, b};
        return ea * eb;
    endfunction

    // An edge matches when its sign equals the triangle orientation
    function automatic logic edge_ok(input logic signed [c_PW-1:0] e,
                                     input logic                   o_neg);
        if (e == '0)
            return c_EDGE_INCL;
        else
            return (e[c_PW-1] == o_neg);
    endfunction

    state_t              r_state;
    logic                r_rst_done;
    logic [COORD_W-1:0]  r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y;
    logic                r_o_neg;
    logic                r_degen;
    logic [15:0]         r_idx;

    // Pipeline registers: stage 0 captured point, stage 1 differences, stage 2 products
    logic                r_v0, r_v1, r_v2;
    logic [COORD_W-1:0]  r_x0, r_y0;
    logic [15:0]         r_i0, r_i1, r_i2;
    logic signed [c_DW-1:0] r_dx1, r_dy1, r_dx2, r_dy2, r_dx3, r_dy3;
    logic signed [c_PW-1:0] r_m1a, r_m1b, r_m2a, r_m2b, r_m3a, r_m3b;

    // Result FIFO
    logic [17:0]         r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr, r_rd;
    logic [c_AW:0]       r_count;

    logic                w_tri_acc;
    logic                w_pt_acc;
    logic                w_any_inflight;
    logic [1:0]          w_inflight;
    logic [c_AW+1:0]     w_occ_total;
    logic signed [c_PW-1:0] w_o;
    logic signed [c_PW-1:0] w_e1, w_e2, w_e3;
    logic                w_inside;
    logic                w_push, w_pop;
    logic [17:0]         w_head;

    assign w_any_inflight = r_v0 | r_v1 | r_v2;
    assign w_inflight     = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, r_v2};
    assign w_occ_total    = {1'b0, r_count} + {{c_AW{1'b0}}, w_inflight};

    // The triangle may only change when no point still needs the old one
    assign tri_ready = r_rst_done &&
                       ((r_state == S_NO_TRI) || ((r_state == S_RUN) && !w_any_inflight));
    // Credit counts in-flight points so the FIFO can never overflow
    assign pt_ready  = (r_state == S_RUN) && !tri_valid && (w_occ_total < c_DEPTH);

    assign w_tri_acc = tri_valid && tri_ready;
    assign w_pt_acc  = pt_valid && pt_ready;

    assign w_o = mul(diff(r_p1x, r_p3x), diff(r_p2y, r_p3y))
               - mul(diff(r_p2x, r_p3x), diff(r_p1y, r_p3y));

    // Control FSM: triangle capture, orientation setup and index counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_NO_TRI;
            r_rst_done <= 1'b0;
            r_p1x      <= '0;
            r_p1y      <= '0;
            r_p2x      <= '0;
            r_p2y      <= '0;
            r_p3x      <= '0;
            r_p3y      <= '0;
            r_o_neg    <= 1'b0;
            r_degen    <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_tri_acc) begin
                r_p1x <= tri_p1x;
                r_p1y <= tri_p1y;
                r_p2x <= tri_p2x;
                r_p2y <= tri_p2y;
                r_p3x <= tri_p3x;
                r_p3y <= tri_p3y;
            end
            case (r_state)
                S_NO_TRI: begin
                    if (w_tri_acc)
                        r_state <= S_SETUP;
                end
                S_SETUP: begin
                    r_o_neg <= w_o[c_PW-1];
                    r_degen <= (w_o == '0);
                    r_idx   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_tri_acc)
                        r_state <= S_SETUP;
                    else if (w_pt_acc)
                        r_idx <= r_idx + 16'd1;
                end
                default: r_state <= S_NO_TRI;
            endcase
        end
    end

    // Stage valid bits; reset discards every in-flight point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v0 <= w_pt_acc;
            r_v1 <= r_v0;
            r_v2 <= r_v1;
        end
    end

    // Stage datapath: capture point, then vertex-minus-point differences, then products
    always_ff @(posedge clk) begin
        if (w_pt_acc) begin
            r_x0 <= pt_x;
            r_y0 <= pt_y;
            r_i0 <= r_idx;
        end
        if (r_v0) begin
            r_dx1 <= diff(r_p1x, r_x0);
            r_dy1 <= diff(r_p1y, r_y0);
            r_dx2 <= diff(r_p2x, r_x0);
            r_dy2 <= diff(r_p2y, r_y0);
            r_dx3 <= diff(r_p3x, r_x0);
            r_dy3 <= diff(r_p3y, r_y0);
            r_i1  <= r_i0;
        end
        if (r_v1) begin
            r_m1a <= mul(r_dx1, r_dy2);
            r_m1b <= mul(r_dx2, r_dy1);
            r_m2a <= mul(r_dx2, r_dy3);
            r_m2b <= mul(r_dx3, r_dy2);
            r_m3a <= mul(r_dx3, r_dy1);
            r_m3b <= mul(r_dx1, r_dy3);
            r_i2  <= r_i1;
        end
    end

    // Edge functions for (p1,p2), (p2,p3), (p3,p1) against the point
    assign w_e1 = r_m1a - r_m1b;
    assign w_e2 = r_m2a - r_m2b;
    assign w_e3 = r_m3a - r_m3b;
    assign w_inside = !r_degen && edge_ok(w_e1, r_o_neg)
                               && edge_ok(w_e2, r_o_neg)
                               && edge_ok(w_e3, r_o_neg);

    assign w_push = r_v2;
    assign w_pop  = res_valid && res_ready;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: {inside, degenerate, index}
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= {w_inside, r_degen, r_i2};
    end

    // Head fields are gated so they read zero whenever no result is offered
    assign w_head         = r_mem[r_rd];
    assign res_valid      = (r_count != '0);
    assign res_inside     = res_valid && w_head[17];
    assign res_degenerate = res_valid && w_head[16];
    assign res_index      = res_valid ? w_head[15:0] : 16'd0;
    assign busy           = res_valid || w_any_inflight;

endmodule
`default_nettype wire

// File: tb/tb_point_in_tri_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_point_in_tri_pipe
// Description : Self-checking bench for point_in_tri_pipe with a behavioural
//               geometric model and an in-order result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_point_in_tri_pipe;

    localparam int CW    = 11;
    localparam int DEPTH = 8;
`ifdef POINT_IN_TRI_EDGE_INCLUSIVE_EN
    localparam bit INCL = 1'b1;
`else
    localparam bit INCL = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          tri_valid;
    logic          tri_ready;
    logic [CW-1:0] tri_p1x, tri_p1y, tri_p2x, tri_p2y, tri_p3x, tri_p3y;
    logic          pt_valid;
    logic          pt_ready;
    logic [CW-1:0] pt_x, pt_y;
    logic          res_valid;
    logic          res_ready;
    logic          res_inside;
    logic          res_degenerate;
    logic [15:0]   res_index;
    logic          busy;

    int            total;
    int            bad;
    int            tx[3];
    int            ty[3];
    int            tb_idx;
    int            px, py;
    bit            rr_rand;
    logic [17:0]   exp_q[$];

    point_in_tri_pipe #(.COORD_W(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_p1x(tri_p1x), .tri_p1y(tri_p1y),
        .tri_p2x(tri_p2x), .tri_p2y(tri_p2y),
        .tri_p3x(tri_p3x), .tri_p3y(tri_p3y),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_inside(res_inside), .res_degenerate(res_degenerate),
        .res_index(res_index), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Signed area of triangle (a,b,c), positive for counter-clockwise
    function automatic longint orient(input longint ax, input longint ay,
                                      input longint bx, input longint by,
                                      input longint cx, input longint cy);
        return (ax - cx) * (by - cy) - (bx - cx) * (ay - cy);
    endfunction

    // Geometric reference: inside when the point lies on the same side of all edges
    function automatic logic [17:0] model_res(input int x, input int y, input int idx);
        longint o, e;
        logic   ins, dg;
        o   = orient(tx[0], ty[0], tx[1], ty[1], tx[2], ty[2]);
        dg  = (o == 0);
        ins = !dg;
        for (int k = 0; k < 3; k++) begin
            e = orient(tx[k], ty[k], tx[(k+1)%3], ty[(k+1)%3], x, y);
            if (e == 0) begin
                if (!INCL) ins = 1'b0;
            end else if ((e > 0) != (o > 0)) begin
                ins = 1'b0;
            end
        end
        return {ins, dg, 16'(idx)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic load_tri(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy);
        logic ok;
        tri_p1x = CW'(ax); tri_p1y = CW'(ay);
        tri_p2x = CW'(bx); tri_p2y = CW'(by);
        tri_p3x = CW'(cx); tri_p3y = CW'(cy);
        tri_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = tri_ready;
            @(posedge clk); #1;
        end
        tri_valid = 1'b0;
        chk("tri_accept", {31'd0, ok}, 32'd1);
        tx[0] = ax; ty[0] = ay;
        tx[1] = bx; ty[1] = by;
        tx[2] = cx; ty[2] = cy;
        tb_idx = 0;
    endtask

    // ei/ed >= 0 overrides the model with a literal expectation
    task automatic send_pt(input int x, input int y, input int ei, input int ed);
        logic        ok;
        logic [17:0] e;
        pt_x = CW'(x);
        pt_y = CW'(y);
        pt_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (pt_ready) begin
                ok = 1'b1;
                e = model_res(x, y, tb_idx);
                if (ei >= 0) e[17] = ei[0];
                if (ed >= 0) e[16] = ed[0];
                exp_q.push_back(e);
                tb_idx = (tb_idx + 1) % 65536;
            end
            @(posedge clk); #1;
        end
        pt_valid = 1'b0;
        chk("pt_accept", {31'd0, ok}, 32'd1);
    endtask

    // Hold pt_valid for a number of cycles, new random point after every acceptance
    task automatic stream(input int cycles, output int acc);
        logic took;
        acc = 0;
        pt_x = CW'(px);
        pt_y = CW'(py);
        pt_valid = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            took = pt_ready;
            if (took) begin
                exp_q.push_back(model_res(px, py, tb_idx));
                tb_idx = (tb_idx + 1) % 65536;
                acc++;
            end
            @(posedge clk); #1;
            if (took) begin
                px = int'($urandom_range(0, 2047));
                py = int'($urandom_range(0, 2047));
                pt_x = CW'(px);
                pt_y = CW'(py);
            end
        end
        pt_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(posedge clk); #1;
            done = (exp_q.size() == 0) && !busy;
        end
        chk("drain", {31'd0, done}, 32'd1);
    endtask

    // Random backpressure on the result port
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rr_rand) res_ready = 1'($urandom_range(0, 1));
        end
    end

    // Result scoreboard and hold-stability monitor, sampled mid-cycle
    initial begin
        logic        ph;
        logic [17:0] pv, got, e;
        ph = 1'b0;
        pv = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ph = 1'b0;
            end else begin
                got = {res_inside, res_degenerate, res_index};
                if (ph) begin
                    total++;
                    assert (res_valid === 1'b1 && got === pv)
                    else begin
                        bad++;
                        $error("FAIL res_hold got=%0h want=%0h", {res_valid, got}, {1'b1, pv});
                    end
                end
                if (res_valid === 1'b1 && res_ready === 1'b1) begin
                    total++;
                    assert (exp_q.size() > 0)
                    else begin
                        bad++;
                        $error("FAIL res_extra got=%0h want=none", got);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        total++;
                        assert (got === e)
                        else begin
                            bad++;
                            $error("FAIL res_data got ins=%0d deg=%0d idx=%0d want ins=%0d deg=%0d idx=%0d",
                                   got[17], got[16], got[15:0], e[17], e[16], e[15:0]);
                        end
                    end
                end
                ph = (res_valid === 1'b1) && (res_ready !== 1'b1);
                pv = got;
            end
        end
    end

    initial begin
        int acc;
        int cx, cy;
        total = 0; bad = 0; tb_idx = 0; rr_rand = 1'b0;
        rst = 1'b1; tri_valid = 1'b0; pt_valid = 1'b0; res_ready = 1'b0;
        tri_p1x = '0; tri_p1y = '0; tri_p2x = '0; tri_p2y = '0; tri_p3x = '0; tri_p3y = '0;
        pt_x = '0; pt_y = '0; px = 0; py = 0;
        tx = '{0, 0, 0}; ty = '{0, 0, 0};

        // Reset state
        #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pt_ready", {31'd0, pt_ready}, 32'd0);
        chk("rst_tri_ready", {31'd0, tri_ready}, 32'd0);
        chk("rst_res_index", {16'd0, res_index}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("tri_ready_before_edge", {31'd0, tri_ready}, 32'd0);
        @(posedge clk); #1;
        chk("tri_ready_after_edge", {31'd0, tri_ready}, 32'd1);

        // Right triangle, strict and edge cases
        res_ready = 1'b1;
        load_tri(0, 0, 10, 0, 0, 10);
        send_pt(2, 2, 1, 0);
        send_pt(10, 10, 0, 0);
        send_pt(0, 0, int'(INCL), 0);
        send_pt(5, 0, int'(INCL), 0);
        send_pt(5, 5, int'(INCL), 0);
        send_pt(11, 0, 0, 0);
        drain();

        // Clockwise triangle and extreme coordinates
        load_tri(0, 0, 0, 10, 10, 0);
        send_pt(2, 2, 1, 0);
        send_pt(2047, 2047, 0, 0);
        drain();

        // Degenerate triangle
        load_tri(0, 0, 5, 5, 10, 10);
        send_pt(1, 1, 0, 1);
        send_pt(5, 5, 0, 1);
        drain();

        // Credit limit: no drain, continuous offer
        res_ready = 1'b0;
        load_tri(100, 100, 1900, 200, 900, 1800);
        px = 900; py = 600;
        stream(30, acc);
        chk("credit_accepted", acc, DEPTH);
        chk("credit_pt_ready", {31'd0, pt_ready}, 32'd0);
        chk("credit_res_valid", {31'd0, res_valid}, 32'd1);
        chk("credit_busy", {31'd0, busy}, 32'd1);
        res_ready = 1'b1;
        stream(20, acc);
        chk("credit_resume", {31'd0, acc > 0}, 32'd1);
        drain();

        // Triangle reload keeps queued results, index restarts
        res_ready = 1'b0;
        send_pt(500, 500, -1, -1);
        send_pt(1000, 400, -1, -1);
        send_pt(20, 2000, -1, -1);
        load_tri(0, 0, 10, 0, 0, 10);
        chk("reload_queued", {31'd0, res_valid}, 32'd1);
        send_pt(2, 2, 1, 0);
        send_pt(10, 10, 0, 0);
        res_ready = 1'b1;
        drain();

        // Random triangles and points with random gaps and backpressure
        rr_rand = 1'b1;
        for (int t = 0; t < 4; t++) begin
            load_tri(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
            cx = (tx[0] + tx[1] + tx[2]) / 3;
            cy = (ty[0] + ty[1] + ty[2]) / 3;
            for (int p = 0; p < 25; p++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 7) == 0) begin
                    px = tx[p % 3];
                    py = ty[p % 3];
                end else begin
                    px = cx + int'($urandom_range(0, 800)) - 400;
                    py = cy + int'($urandom_range(0, 800)) - 400;
                    if (px < 0) px = 0;
                    if (px > 2047) px = 2047;
                    if (py < 0) py = 0;
                    if (py > 2047) py = 2047;
                end
                send_pt(px, py, -1, -1);
            end
        end
        drain();
        rr_rand = 1'b0;

        // Reset with three points in flight
        res_ready = 1'b0;
        load_tri(0, 0, 10, 0, 0, 10);
        send_pt(2, 2, 1, 0);
        send_pt(3, 3, 1, 0);
        send_pt(20, 20, 0, 0);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_pt_ready", {31'd0, pt_ready}, 32'd0);
        chk("midrst_tri_ready", {31'd0, tri_ready}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_tri", {31'd0, tri_ready}, 32'd1);
        chk("midrst_pt_ready_idle", {31'd0, pt_ready}, 32'd0);
        res_ready = 1'b1;
        load_tri(0, 0, 10, 0, 0, 10);
        send_pt(2, 2, 1, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
